// File: rtl/multi_tone_psg.sv
// multi_tone_psg: nibble-bus programmed multi-channel square/noise tone generator.
// Host writes an address nibble (A0=0), then data nibbles (A0=1) into a
// per-channel register file; each channel divides a shared prescaler tick.

// One tone channel: shadow period, control bits, down-counter, noise LFSR.
module psg_channel #(
  parameter int          DIV_BITS  = 12,
  parameter logic [14:0] LFSR_SEED = 15'h0001
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       tick,
  input  logic       wrEn,
  input  logic [1:0] regSel,
  input  logic [3:0] din,
  output logic       phase
);
  logic [DIV_BITS-1:0] shadow;
  logic [DIV_BITS-1:0] cnt;
  logic                en;
  logic                mode;
  logic [14:0]         lfsr;
  logic [14:0]         lfsrNext;

  // x^15 + x^14 + 1, shifting toward bit0; feedback enters at bit14
  assign lfsrNext = {lfsr[0] ^ lfsr[1], lfsr[14:1]};

  // Host writes land in the shadow/control regs; the counter uses the
  // registered EN/MODE, so a same-cycle control write acts one cycle later.
  always_ff @(posedge CLK) begin
    if (RST) begin
      shadow <= '0;
      en     <= 1'b0;
      mode   <= 1'b0;
      cnt    <= '0;
      phase  <= 1'b0;
      lfsr   <= LFSR_SEED;
    end else begin
      if (wrEn) begin
        case (regSel)
          2'd0: shadow[3:0]  <= din;
          2'd1: shadow[7:4]  <= din;
          2'd2: shadow[11:8] <= din;
          default: begin
            en   <= din[0];
            mode <= din[1];
          end
        endcase
      end
      if (!en) begin
        phase <= 1'b0;
        cnt   <= '0;
      end else if (tick) begin
        if (cnt != '0) begin
          cnt <= cnt - DIV_BITS'(1);
        end else if (shadow == '0) begin
          // period 0 is silence; cnt stays at 0 so it re-checks every tick
          phase <= 1'b0;
        end else begin
          // shadow is only sampled here, so a half-cycle is never cut short
          cnt <= shadow - DIV_BITS'(1);
          if (mode) begin
            lfsr  <= lfsrNext;
            phase <= lfsrNext[0];
          end else begin
            phase <= ~phase;
          end
        end
      end
    end
  end
endmodule

module multi_tone_psg #(
  parameter int          NUM_CH        = 4,
  parameter int          DIV_BITS      = 12,
  parameter int          PRESCALE_BITS = 4,
  parameter logic [14:0] LFSR_SEED     = 15'h0001
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              A0,
  input  logic              WR,
  input  logic [3:0]        D,
  output logic [NUM_CH-1:0] SOUT,
  output logic [2:0]        MIX
);
  logic [3:0]               addr;
  logic [PRESCALE_BITS-1:0] prescale;
  logic                     tick;
  logic [2:0]               popCnt;

  // Address latch; no auto-increment, only address-phase writes touch it
  always_ff @(posedge CLK) begin
    if (RST)            addr <= '0;
    else if (WR && !A0) addr <= D;
  end

  // Free-running prescaler; tick is the single all-ones cycle
  always_ff @(posedge CLK) begin
    if (RST) prescale <= '0;
    else     prescale <= prescale + PRESCALE_BITS'(1);
  end

  assign tick = &prescale;

  // Index = ch*4 + r; indices for channels beyond NUM_CH match no instance
  for (genvar g = 0; g < NUM_CH; g++) begin : gCh
    logic wrSel;
    assign wrSel = WR && A0 && (addr[3:2] == 2'(g));
    psg_channel #(.DIV_BITS(DIV_BITS), .LFSR_SEED(LFSR_SEED)) uCh (
      .CLK   (CLK),
      .RST   (RST),
      .tick  (tick),
      .wrEn  (wrSel),
      .regSel(addr[1:0]),
      .din   (D),
      .phase (SOUT[g])
    );
  end

  // Population count of the current channel outputs
  always_comb begin
    popCnt = '0;
    for (int i = 0; i < NUM_CH; i++) popCnt = popCnt + {2'b00, SOUT[i]};
  end

  // MIX is the registered popcount, one CLK behind SOUT
  always_ff @(posedge CLK) begin
    if (RST) MIX <= '0;
    else     MIX <= popCnt;
  end
endmodule

// File: tb/tb_multi_tone_psg.sv
// tb_multi_tone_psg: scenario tasks against an arithmetic timing/LFSR model.
// cyc counts CLK edges since the last reset edge; ticks fall on cyc%16 == 0.
module tb_multi_tone_psg;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       A0  = 1'b0;
  logic       WR  = 1'b0;
  logic [3:0] D   = 4'h0;
  logic [3:0] SOUT;
  logic [2:0] MIX;
  logic [1:0] SOUT2;
  logic [2:0] MIX2;
  int cyc = 0;
  int nChecks = 0;
  int nPass = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= RST ? 0 : cyc + 1;

  multi_tone_psg #(.NUM_CH(4)) dut (
    .CLK(CLK), .RST(RST), .A0(A0), .WR(WR), .D(D), .SOUT(SOUT), .MIX(MIX));
  multi_tone_psg #(.NUM_CH(2)) dut2 (
    .CLK(CLK), .RST(RST), .A0(A0), .WR(WR), .D(D), .SOUT(SOUT2), .MIX(MIX2));

  function automatic int nextTick(input int e);
    return ((e / 16) + 1) * 16;
  endfunction

  task automatic doReset();
    RST = 1'b1; WR = 1'b0;
    @(negedge CLK); @(negedge CLK);
    RST = 1'b0;
  endtask

  // address write then data write on consecutive edges; returns data edge
  task automatic regWrite(input logic [3:0] idx, input logic [3:0] val, output int wEdge);
    WR = 1'b1; A0 = 1'b0; D = idx;
    @(negedge CLK);
    A0 = 1'b1; D = val;
    @(negedge CLK);
    WR = 1'b0; A0 = 1'b0;
    wEdge = cyc;
  endtask

  // edge number at which SOUT[ch] next changes, -1 if budget expires
  task automatic waitChange(input int ch, input int budget, output int when);
    logic b0;
    b0 = SOUT[ch];
    when = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (SOUT[ch] !== b0) begin when = cyc; break; end
    end
  endtask

  task automatic test_reset();
    int bad;
    doReset();
    nChecks++; if (SOUT !== 4'h0 || MIX !== 3'd0) $display("FAIL reset_out SOUT=%b MIX=%0d want 0000/0", SOUT, MIX); else nPass++;
    nChecks++; if (SOUT2 !== 2'b00 || MIX2 !== 3'd0) $display("FAIL reset_out2 SOUT=%b MIX=%0d want 00/0", SOUT2, MIX2); else nPass++;
    bad = 0;
    repeat (48) begin @(negedge CLK); if (SOUT !== 4'h0 || MIX !== 3'd0) bad++; end
    nChecks++; if (bad != 0) $display("FAIL reset_idle active_cycles=%0d want 0", bad); else nPass++;
  endtask

  task automatic test_square_basic();
    int e, t, w;
    doReset();
    regWrite(4'h0, 4'h3, e); regWrite(4'h1, 4'h0, e);
    regWrite(4'h2, 4'h0, e); regWrite(4'h3, 4'h1, e);
    t = nextTick(e);
    waitChange(0, 64, w);
    nChecks++; if (w != t) $display("FAIL sq_first_rise edge=%0d want %0d", w, t); else nPass++;
    nChecks++; if (SOUT !== 4'b0001 || MIX !== 3'd0) $display("FAIL sq_rise_state SOUT=%b MIX=%0d want 0001/0", SOUT, MIX); else nPass++;
    @(negedge CLK);
    nChecks++; if (MIX !== 3'd1) $display("FAIL sq_mix_lag MIX=%0d want 1", MIX); else nPass++;
    waitChange(0, 80, w);
    nChecks++; if (w != t + 48 || SOUT !== 4'b0000) $display("FAIL sq_fall edge=%0d SOUT=%b want %0d/0000", w, SOUT, t + 48); else nPass++;
    @(negedge CLK);
    nChecks++; if (MIX !== 3'd0) $display("FAIL sq_mix_fall MIX=%0d want 0", MIX); else nPass++;
    waitChange(0, 80, w);
    nChecks++; if (w != t + 96) $display("FAIL sq_rise2 edge=%0d want %0d", w, t + 96); else nPass++;
  endtask

  task automatic test_square_random();
    int e, t, w, ch, p;
    for (int it = 0; it < 3; it++) begin
      doReset();
      ch = $urandom_range(0, 3);
      p  = $urandom_range(1, 6);
      regWrite(4'(ch * 4), 4'(p), e);
      regWrite(4'(ch * 4 + 3), 4'h1, e);
      t = nextTick(e);
      waitChange(ch, 40, w);
      nChecks++; if (w != t) $display("FAIL rnd_first ch=%0d p=%0d edge=%0d want %0d", ch, p, w, t); else nPass++;
      for (int k = 1; k <= 3; k++) begin
        waitChange(ch, p * 16 + 8, w);
        nChecks++; if (w != t + k * p * 16) $display("FAIL rnd_toggle ch=%0d p=%0d k=%0d edge=%0d want %0d", ch, p, k, w, t + k * p * 16); else nPass++;
      end
      nChecks++; if ((SOUT & ~(4'b0001 << ch)) !== 4'h0) $display("FAIL rnd_others ch=%0d SOUT=%b want others 0", ch, SOUT); else nPass++;
    end
  endtask

  task automatic test_glitch_free();
    int e, t, w;
    doReset();
    regWrite(4'h4, 4'h2, e); regWrite(4'h7, 4'h1, e);
    t = nextTick(e);
    waitChange(1, 40, w);
    nChecks++; if (w != t) $display("FAIL gf_rise edge=%0d want %0d", w, t); else nPass++;
    regWrite(4'h4, 4'h5, e);
    waitChange(1, 40, w);
    nChecks++; if (w != t + 32) $display("FAIL gf_complete edge=%0d want %0d", w, t + 32); else nPass++;
    waitChange(1, 100, w);
    nChecks++; if (w != t + 112) $display("FAIL gf_new1 edge=%0d want %0d", w, t + 112); else nPass++;
    waitChange(1, 100, w);
    nChecks++; if (w != t + 192) $display("FAIL gf_new2 edge=%0d want %0d", w, t + 192); else nPass++;
  endtask

  task automatic test_silence_disable();
    int e, t, w, bad;
    doReset();
    regWrite(4'h3, 4'h1, e);
    bad = 0;
    repeat (100) begin @(negedge CLK); if (SOUT !== 4'h0) bad++; end
    nChecks++; if (bad != 0) $display("FAIL silent_period0 active_cycles=%0d want 0", bad); else nPass++;
    regWrite(4'h0, 4'h3, e);
    t = nextTick(e);
    waitChange(0, 40, w);
    nChecks++; if (w != t) $display("FAIL dis_rise edge=%0d want %0d", w, t); else nPass++;
    repeat (5) @(negedge CLK);
    regWrite(4'h3, 4'h0, e);
    nChecks++; if (SOUT[0] !== 1'b1) $display("FAIL dis_write_edge SOUT0=%b want 1", SOUT[0]); else nPass++;
    @(negedge CLK);
    nChecks++; if (SOUT[0] !== 1'b0) $display("FAIL dis_forced SOUT0=%b want 0", SOUT[0]); else nPass++;
    bad = 0;
    repeat (20) begin @(negedge CLK); if (SOUT !== 4'h0) bad++; end
    nChecks++; if (bad != 0) $display("FAIL dis_hold active_cycles=%0d want 0", bad); else nPass++;
    regWrite(4'h3, 4'h1, e);
    t = nextTick(e);
    waitChange(0, 40, w);
    nChecks++; if (w != t) $display("FAIL reen_rise edge=%0d want %0d", w, t); else nPass++;
  endtask

  task automatic test_noise();
    int e, t, lfsr, fb;
    logic expBit;
    doReset();
    regWrite(4'h8, 4'h1, e); regWrite(4'hB, 4'h3, e);
    t = nextTick(e);
    lfsr = 1;
    while (cyc < t) @(negedge CLK);
    for (int k = 0; k < 200; k++) begin
      fb = (lfsr ^ (lfsr >> 1)) & 1;
      lfsr = (lfsr >> 1) | (fb << 14);
      expBit = 1'(lfsr & 1);
      nChecks++; if (SOUT[2] !== expBit) $display("FAIL noise_step k=%0d SOUT2=%b want %b", k, SOUT[2], expBit); else nPass++;
      repeat (16) @(negedge CLK);
    end
  endtask

  task automatic test_multi();
    int e, t;
    logic [3:0] prev;
    doReset();
    for (int c = 0; c < 4; c++) regWrite(4'(c * 4), 4'h1, e);
    while (cyc % 16 != 1) @(negedge CLK);
    for (int c = 0; c < 4; c++) regWrite(4'(c * 4 + 3), 4'h1, e);
    t = nextTick(e);
    while (cyc < t) @(negedge CLK);
    nChecks++; if (SOUT !== 4'hF || MIX !== 3'd0) $display("FAIL multi_rise SOUT=%b MIX=%0d want 1111/0", SOUT, MIX); else nPass++;
    @(negedge CLK);
    nChecks++; if (MIX !== 3'd4) $display("FAIL multi_mix4 MIX=%0d want 4", MIX); else nPass++;
    while (cyc < t + 16) @(negedge CLK);
    nChecks++; if (SOUT !== 4'h0 || MIX !== 3'd4) $display("FAIL multi_fall SOUT=%b MIX=%0d want 0000/4", SOUT, MIX); else nPass++;
    @(negedge CLK);
    nChecks++; if (MIX !== 3'd0) $display("FAIL multi_mix0 MIX=%0d want 0", MIX); else nPass++;
    for (int c = 0; c < 4; c++) begin
      regWrite(4'(c * 4), 4'($urandom_range(1, 3)), e);
      regWrite(4'(c * 4 + 3), 4'($urandom_range(0, 1)), e);
    end
    prev = SOUT;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      nChecks++; if (MIX !== 3'($countones(prev))) $display("FAIL mix_track cyc=%0d MIX=%0d want %0d", cyc, MIX, $countones(prev)); else nPass++;
      prev = SOUT;
    end
  endtask

  task automatic test_discard();
    int e, t, w, bad;
    doReset();
    regWrite(4'h4, 4'h1, e);
    regWrite(4'hF, 4'h1, e);
    bad = 0;
    repeat (64) begin @(negedge CLK); if (SOUT2 !== 2'b00) bad++; end
    nChecks++; if (bad != 0) $display("FAIL discard_idx15 active_cycles=%0d want 0", bad); else nPass++;
    regWrite(4'h7, 4'h1, e);
    t = nextTick(e);
    w = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (SOUT2[1] === 1'b1) begin w = cyc; break; end
    end
    nChecks++; if (w != t) $display("FAIL ch2_enable_rise edge=%0d want %0d", w, t); else nPass++;
  endtask

  task automatic test_reset_mid();
    int e, t, w;
    doReset();
    regWrite(4'h0, 4'h1, e); regWrite(4'h1, 4'h1, e); regWrite(4'h3, 4'h1, e);
    regWrite(4'h4, 4'h2, e); regWrite(4'h7, 4'h1, e);
    repeat (40) @(negedge CLK);
    RST = 1'b1; WR = 1'b1; A0 = 1'b0; D = 4'h5;
    @(negedge CLK);
    RST = 1'b0; WR = 1'b0;
    nChecks++; if (SOUT !== 4'h0 || MIX !== 3'd0) $display("FAIL rstmid_out SOUT=%b MIX=%0d want 0000/0", SOUT, MIX); else nPass++;
    // data-only write: reaches period[3:0] of ch0 only if the latch reads 0
    WR = 1'b1; A0 = 1'b1; D = 4'h1;
    @(negedge CLK);
    WR = 1'b0; A0 = 1'b0;
    regWrite(4'h3, 4'h1, e);
    t = nextTick(e);
    waitChange(0, 40, w);
    nChecks++; if (w != t) $display("FAIL rstmid_rise edge=%0d want %0d", w, t); else nPass++;
    waitChange(0, 40, w);
    nChecks++; if (w != t + 16) $display("FAIL rstmid_period edge=%0d want %0d", w, t + 16); else nPass++;
    nChecks++; if (SOUT[3:1] !== 3'b000) $display("FAIL rstmid_others SOUT=%b want xxx0 others 0", SOUT); else nPass++;
  endtask

  task automatic test_fff();
    int e, t, w;
    doReset();
    regWrite(4'h0, 4'hF, e); regWrite(4'h1, 4'hF, e);
    regWrite(4'h2, 4'hF, e); regWrite(4'h3, 4'h1, e);
    t = nextTick(e);
    waitChange(0, 40, w);
    nChecks++; if (w != t) $display("FAIL fff_rise edge=%0d want %0d", w, t); else nPass++;
    waitChange(0, 65600, w);
    nChecks++; if (w != t + 65520) $display("FAIL fff_half edge=%0d want %0d", w, t + 65520); else nPass++;
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_square_basic();
    test_square_random();
    test_glitch_free();
    test_silence_disable();
    test_noise();
    test_multi();
    test_discard();
    test_reset_mid();
    test_fff();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
